// File: rtl/icache_refill.sv
// icache_refill: single-outstanding instruction-cache miss refill engine.
// A fetch miss is latched, one word-aligned read is issued to memory, and the
// returned word is written into the icache and forwarded to fetch. A pipeline
// flush abandons the result. A bounded wait turns a lost response into a
// one-cycle refill_err pulse.
module icache_refill #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_valid,
    input  logic [31:0] miss_addr,
    input  logic        flush,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        w_en,
    output logic [31:0] w_addr,
    output logic [31:0] w_data,
    output logic        refill_done,
    output logic [31:0] refill_data,
    output logic        refill_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] addr_r;
    logic [31:0] addr_s;
    logic [31:0] data_r;
    logic [31:0] data_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_s;
    logic        req_r;
    logic        wen_r;
    logic        done_r;
    logic        err_r;
    logic        err_s;
    logic        timeout_s;
    logic        addr_lsb_unused_s;

    // Byte offset of the miss address is irrelevant: requests are word aligned.
    assign addr_lsb_unused_s = ^miss_addr[1:0];

    // The current WAIT/DRAIN cycle is the last one allowed without a response.
    always_comb begin
        timeout_s = (cnt_r == (TIMEOUT - 8'd1));
    end

    // Next-state, address/data capture and timeout counter update.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        data_s  = data_r;
        cnt_s   = cnt_r;
        err_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (miss_valid && !flush) begin
                    addr_s  = {miss_addr[31:2], 2'b00};
                    state_s = S_REQ;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    // Request accepted: it is outstanding even if fetch no
                    // longer wants it, so a flush here must drain the reply.
                    cnt_s = 8'd0;
                    if (flush) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_WAIT;
                    end
                end else if (flush) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (flush) begin
                        state_s = S_IDLE;
                    end else begin
                        data_s  = mem_rdata;
                        state_s = S_WRITE;
                    end
                end else if (timeout_s) begin
                    err_s   = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                    if (flush) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_WAIT;
                    end
                end
            end
            S_WRITE: begin
                state_s = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rvalid) begin
                    state_s = S_IDLE;
                end else if (timeout_s) begin
                    err_s   = 1'b1;
                    state_s = S_IDLE;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, latched address/data and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            addr_r  <= 32'd0;
            data_r  <= 32'd0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            cnt_r   <= cnt_s;
        end
    end

    // Per-state output strobes, registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r  <= 1'b0;
            wen_r  <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            req_r  <= (state_s == S_REQ);
            wen_r  <= (state_s == S_WRITE);
            done_r <= (state_s == S_WRITE);
            err_r  <= err_s;
        end
    end

    // Fetch holds while a refill is in progress or one is about to start.
    always_comb begin
        stall = (state_r != S_IDLE) || (miss_valid && !flush);
    end

    // A flush during the write cycle still fills the cache line but must not
    // hand the instruction to a pipeline that has been redirected.
    always_comb begin
        refill_done = done_r && !flush;
    end

    assign mem_req     = req_r;
    assign mem_addr    = addr_r;
    assign w_en        = wen_r;
    assign w_addr      = addr_r;
    assign w_data      = data_r;
    assign refill_data = data_r;
    assign refill_err  = err_r;

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: hand-written vector table, asynchronous reset
// sequences, then random traffic checked against a transaction-level model.
module tb_icache_refill;

    localparam logic [7:0] TO = 8'd4;

    logic        clk;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        flush;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        refill_done;
    logic [31:0] refill_data;
    logic        refill_err;

    int n_cmp  = 0;
    int n_fail = 0;

    icache_refill #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .flush(flush),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .refill_done(refill_done), .refill_data(refill_data),
        .refill_err(refill_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          mi, fl, rd, rv;
        logic [31:0] ad, dt;
        bit          st, rq, we, dn, er;
        logic [31:0] ea, ed;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input bit mi, input bit fl, input bit rd, input bit rv,
                                input logic [31:0] ad, input logic [31:0] dt,
                                input bit st, input bit rq, input bit we, input bit dn,
                                input bit er, input logic [31:0] ea, input logic [31:0] ed);
        vec_t v;
        v.mi = mi; v.fl = fl; v.rd = rd; v.rv = rv; v.ad = ad; v.dt = dt;
        v.st = st; v.rq = rq; v.we = we; v.dn = dn; v.er = er; v.ea = ea; v.ed = ed;
        vecs.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    // Transaction view: a request waiting to be issued, a request in flight
    // (wanted or not), a pending cache write, and an error pulse.
    bit          m_pend, m_fly, m_want, m_wr, m_err;
    int          m_wait;
    logic [31:0] m_addr, m_data;

    task automatic model_reset();
        m_pend = 1'b0; m_fly = 1'b0; m_want = 1'b0; m_wr = 1'b0; m_err = 1'b0;
        m_wait = 0; m_addr = 32'd0; m_data = 32'd0;
    endtask

    task automatic model_advance();
        bit new_err;
        new_err = 1'b0;
        if (m_wr) begin
            m_wr = 1'b0;
        end else if (m_pend) begin
            if (mem_ready) begin
                m_pend = 1'b0; m_fly = 1'b1; m_wait = 0; m_want = !flush;
            end else if (flush) begin
                m_pend = 1'b0;
            end
        end else if (m_fly) begin
            m_wait = m_wait + 1;
            if (mem_rvalid) begin
                m_fly = 1'b0;
                if (m_want && !flush) begin
                    m_data = mem_rdata;
                    m_wr   = 1'b1;
                end
            end else if (m_wait >= int'(TO)) begin
                m_fly   = 1'b0;
                new_err = 1'b1;
            end else if (flush) begin
                m_want = 1'b0;
            end
        end else if (miss_valid && !flush) begin
            m_pend = 1'b1;
            m_addr = miss_addr & 32'hFFFF_FFFC;
        end
        m_err = new_err;
    endtask

    task automatic model_check();
        chk1("stall", stall, m_pend || m_fly || m_wr || (miss_valid && !flush));
        chk1("mem_req", mem_req, m_pend);
        if (m_pend) chk32("mem_addr", mem_addr, m_addr);
        chk1("w_en", w_en, m_wr);
        if (m_wr) begin
            chk32("w_addr", w_addr, m_addr);
            chk32("w_data", w_data, m_data);
        end
        chk1("refill_done", refill_done, m_wr && !flush);
        if (m_wr && !flush) chk32("refill_data", refill_data, m_data);
        chk1("refill_err", refill_err, m_err);
    endtask

    task automatic drive(input bit mi, input logic [31:0] ad, input bit fl,
                         input bit rd, input bit rv, input logic [31:0] dt);
        miss_valid = mi; miss_addr = ad; flush = fl;
        mem_ready = rd; mem_rvalid = rv; mem_rdata = dt;
    endtask

    // One model-checked cycle: drive at negedge, check, advance model at posedge.
    task automatic step(input bit mi, input logic [31:0] ad, input bit fl,
                        input bit rd, input bit rv, input logic [31:0] dt);
        @(negedge clk);
        drive(mi, ad, fl, rd, rv, dt);
        #1;
        model_check();
        @(posedge clk);
        model_advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        model_reset();
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk1("rst_w_en", w_en, 1'b0);
        chk32("rst_w_data", w_data, 32'd0);
        chk1("rst_refill_done", refill_done, 1'b0);
        chk1("rst_refill_err", refill_err, 1'b0);
        do_reset();

        //   mi fl rd rv addr           data            st rq we dn er  exp_addr      exp_data
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,1, 32'h0,          32'hAAAA_AAAA,  0,0,0,0,0, 32'h0,        32'h0);
        // zero-wait refill
        add(1,0,0,0, 32'h0000_1006,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_1004,32'h0);
        add(0,0,0,1, 32'h0,          32'h0000_0013,  1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,1,1,0, 32'h0000_1004,32'h0000_0013);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // mem_ready low three cycles
        add(1,0,0,0, 32'h0000_2000,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_2000,32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_2000,32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_2000,32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_2000,32'h0);
        add(0,0,0,1, 32'h0,          32'h0000_0055,  1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,1,1,0, 32'h0000_2000,32'h0000_0055);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // flush in WAIT, late response drained
        add(1,0,0,0, 32'h0000_300A,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_3008,32'h0);
        add(0,1,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,1, 32'h0,          32'hDEAD_BEEF,  1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // flush during WRITE: write kept, done suppressed
        add(1,0,0,0, 32'h0000_0044,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_0044,32'h0);
        add(0,0,0,1, 32'h0,          32'h0000_0077,  1,0,0,0,0, 32'h0,        32'h0);
        add(0,1,0,0, 32'h0,          32'h0,          1,0,1,0,0, 32'h0000_0044,32'h0000_0077);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // timeout in WAIT
        add(1,0,0,0, 32'h0000_0050,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_0050,32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,1, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // response in the last allowed WAIT cycle is accepted
        add(1,0,0,0, 32'h0000_0060,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_0060,32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,1, 32'h0,          32'h0000_0099,  1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,1,1,0, 32'h0000_0060,32'h0000_0099);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // miss with flush in IDLE ignored
        add(1,1,0,0, 32'h0000_0070,  32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // flush in REQ without handshake
        add(1,0,0,0, 32'h0000_0080,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,1,0,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_0080,32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // flush together with handshake -> drain
        add(1,0,0,0, 32'h0000_0090,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,1,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_0090,32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,1, 32'h0,          32'h0000_1234,  1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // flush with rvalid in WAIT discards the data
        add(1,0,0,0, 32'h0000_00A0,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_00A0,32'h0);
        add(0,1,0,1, 32'h0,          32'h0000_0005,  1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);
        // timeout in DRAIN
        add(1,0,0,0, 32'h0000_00B0,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_00B0,32'h0);
        add(0,1,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,1, 32'h0,        32'h0);
        // miss during WRITE is not accepted
        add(1,0,0,0, 32'h0000_00C0,  32'h0,          1,0,0,0,0, 32'h0,        32'h0);
        add(0,0,1,0, 32'h0,          32'h0,          1,1,0,0,0, 32'h0000_00C0,32'h0);
        add(0,0,0,1, 32'h0,          32'h0000_0011,  1,0,0,0,0, 32'h0,        32'h0);
        add(1,0,0,0, 32'h0000_00D0,  32'h0,          1,0,1,1,0, 32'h0000_00C0,32'h0000_0011);
        add(0,0,0,0, 32'h0,          32'h0,          0,0,0,0,0, 32'h0,        32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].mi, vecs[i].ad, vecs[i].fl, vecs[i].rd, vecs[i].rv, vecs[i].dt);
            #1;
            chk1($sformatf("v%0d_stall", i), stall, vecs[i].st);
            chk1($sformatf("v%0d_mem_req", i), mem_req, vecs[i].rq);
            if (vecs[i].rq) chk32($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].ea);
            chk1($sformatf("v%0d_w_en", i), w_en, vecs[i].we);
            if (vecs[i].we) begin
                chk32($sformatf("v%0d_w_addr", i), w_addr, vecs[i].ea);
                chk32($sformatf("v%0d_w_data", i), w_data, vecs[i].ed);
            end
            chk1($sformatf("v%0d_refill_done", i), refill_done, vecs[i].dn);
            if (vecs[i].dn) chk32($sformatf("v%0d_refill_data", i), refill_data, vecs[i].ed);
            chk1($sformatf("v%0d_refill_err", i), refill_err, vecs[i].er);
        end

        // Asynchronous reset while a request is being presented.
        do_reset();
        step(1'b1, 32'h0000_4000, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_req_mem_req", mem_req, 1'b0);
        chk32("arst_req_mem_addr", mem_addr, 32'd0);
        chk1("arst_req_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Asynchronous reset in WAIT, then a late response must be ignored.
        step(1'b1, 32'h0000_5008, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        #1;
        chk1("wait_stall", stall, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("arst_wait_stall", stall, 1'b0);
        chk1("arst_wait_w_en", w_en, 1'b0);
        chk1("arst_wait_refill_done", refill_done, 1'b0);
        chk1("arst_wait_refill_err", refill_err, 1'b0);
        chk32("arst_wait_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        // next miss refills normally
        step(1'b1, 32'h0000_6006, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
